// File: rtl/dna_pkg.sv
// Shared types and constants for the device-DNA readout controller.
package dna_pkg;

    localparam int DNA_LENGTH_DEF = 57;

    // Value the simulation model of the DNA primitive shifts out.
    localparam logic [56:0] DNA_SIM_VALUE = 57'h123456789abcdef;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dna_port_ctrl_if.sv
// Requester-facing bundle: level req in, one-cycle ack plus DNA word and status out.
interface dna_port_ctrl_if
    import dna_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DNA_LENGTH = DNA_LENGTH_DEF
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      ack;
    logic [DNA_LENGTH-1:0] dna;
    logic                  dna_valid;
    logic                  busy;

    modport master (output req, input ack, dna, dna_valid, busy);
    modport slave  (input req, output ack, dna, dna_valid, busy);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req_i, last winner drops to lowest priority.
// Latency: grant is combinational; priority pointer advances on the clock when update_i is high.
// Backpressure: none, a grant is only committed when the caller strobes update_i.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             update_i,
    output logic [N_REQ-1:0] grant_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0] prio_q, prio_d;
    logic [IW-1:0] win;
    logic          found;

    // First pass searches from the priority pointer upward, second pass wraps to index 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i >= int'(prio_q))) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        grant_o = found ? (N_REQ'(1) << win) : '0;
        prio_d  = prio_q;
        if (update_i && found) begin
            prio_d = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dna_port_ctrl.sv
// Arbitrated reader of the device DNA primitive; DNA_PORT_CTRL_CACHE_EN serves repeat requests from the stored word.
// Latency: fresh read acks 2 + 2*DNA_LENGTH + 1 cycles after grant; a cached serve acks the next cycle.
// Backpressure: requests are levels held until ack; new requests wait in IDLE until the current read ends.
module dna_port_ctrl
    import dna_pkg::*;
#(
    parameter int DNA_LENGTH = DNA_LENGTH_DEF,
    parameter int N_REQ      = 2
) (
    input  logic            clock,
    input  logic            reset,
    dna_port_ctrl_if.slave  bus,
    output logic            dna_clk,
    output logic            dna_read,
    output logic            dna_shift,
    input  logic            dna_dout
);
`ifdef DNA_PORT_CTRL_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    localparam int CW = $clog2(2 * DNA_LENGTH + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic [N_REQ-1:0]      req_m, arb_gnt;
    logic [DNA_LENGTH-1:0] sr_q, sr_d;
    logic [DNA_LENGTH-1:0] dna_q, dna_d;
    logic                  dna_valid_q, dna_valid_d;
    logic                  clk_q, clk_d;
    logic                  rd_q, rd_d;
    logic                  sh_q, sh_d;
    logic                  arb_upd;
    logic                  cache_hit;

    // A requester still holding req in its ack cycle must not be served twice.
    assign req_m     = bus.req & ~ack_q;
    assign cache_hit = CacheEn && dna_valid_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req_m),
        .update_i (arb_upd),
        .grant_o  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        sr_d        = sr_q;
        dna_d       = dna_q;
        dna_valid_d = dna_valid_q;
        arb_upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_m) begin
                    arb_upd = 1'b1;
                    gnt_d   = arb_gnt;
                    if (cache_hit) begin
                        ack_d = arb_gnt;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
            end
            LOAD: begin
                if (cnt_q == CW'(1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // DOUT is stable while the primitive clock is low.
                if (!clk_q) begin
                    sr_d = {sr_q[DNA_LENGTH-2:0], dna_dout};
                end
                if (cnt_q == CW'(2 * DNA_LENGTH - 1)) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    dna_d       = sr_d;
                    dna_valid_d = 1'b1;
                    ack_d       = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Each phase restarts its counter at 0, so the primitive clock enters low and toggles continuously.
        clk_d = ((state_d == LOAD) || (state_d == SHIFT)) && cnt_d[0];
        rd_d  = (state_d == LOAD);
        sh_d  = (state_d == SHIFT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            sr_q        <= '0;
            dna_q       <= '0;
            dna_valid_q <= 1'b0;
            clk_q       <= 1'b0;
            rd_q        <= 1'b0;
            sh_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            sr_q        <= sr_d;
            dna_q       <= dna_d;
            dna_valid_q <= dna_valid_d;
            clk_q       <= clk_d;
            rd_q        <= rd_d;
            sh_q        <= sh_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.dna       = dna_q;
    assign bus.dna_valid = dna_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign dna_clk       = clk_q;
    assign dna_read      = rd_q;
    assign dna_shift     = sh_q;

endmodule

// File: tb/tb_dna_port_ctrl.sv
// Directed bench for dna_port_ctrl with a behavioural DNA primitive model.
module tb_dna_port_ctrl;
    import dna_pkg::*;

    localparam int L   = DNA_LENGTH_DEF;
    localparam int N   = 2;
    localparam int LAT = 2 + 2 * L + 1;
`ifdef DNA_PORT_CTRL_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic dna_clk, dna_read, dna_shift, dna_dout;
    logic [L-1:0] prim_q;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int sh_cnt   = 0;
    logic mon_en  = 1'b0;
    logic rd_prev = 1'b0;
    logic sh_prev = 1'b0;

    dna_port_ctrl_if #(.N_REQ(N), .DNA_LENGTH(L)) bus ();

    dna_port_ctrl #(.DNA_LENGTH(L), .N_REQ(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dna_clk   (dna_clk),
        .dna_read  (dna_read),
        .dna_shift (dna_shift),
        .dna_dout  (dna_dout)
    );

    always #5 clock = ~clock;

    // DNA primitive: READ loads the word, SHIFT rotates it (DIN tied to DOUT), DOUT is the MSB.
    initial prim_q = '0;
    always @(posedge dna_clk) begin
        if (dna_read)       prim_q <= DNA_SIM_VALUE;
        else if (dna_shift) prim_q <= {prim_q[L-2:0], prim_q[L-1]};
    end
    assign dna_dout = prim_q[L-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("clk_low_idle_done", 64'(dna_clk & (~bus.busy | (|bus.ack))), 64'd0);
            chk("ack_onehot0", 64'($onehot0(bus.ack)), 64'd1);
            chk("rd_sh_edge", 64'(((dna_read != rd_prev) || (dna_shift != sh_prev)) & dna_clk), 64'd0);
            rd_prev = dna_read;
            sh_prev = dna_shift;
            if (dna_read)  rd_cnt++;
            if (dna_shift) sh_cnt++;
        end
    end

    task automatic wait_ack(input string tag, input logic [N-1:0] exp_ack, input int exp_lat);
        int n = 0;
        logic [N-1:0] a = '0;
        while (n < 400 && a == '0) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            a = bus.ack;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_ack"}, 64'(a), 64'(exp_ack));
        bus.req = bus.req & ~a;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int r0, s0, k;
        bus.req = '0;
        repeat (2) @(negedge clock);
        chk("rst_dna", 64'(bus.dna), 64'd0);
        chk("rst_valid", 64'(bus.dna_valid), 64'd0);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pins", 64'({dna_clk, dna_read, dna_shift}), 64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);

        // Single fresh read from requester 0.
        r0 = rd_cnt; s0 = sh_cnt;
        bus.req = 2'b01;
        wait_ack("rd0", 2'b01, LAT);
        chk("rd0_dna", 64'(bus.dna), 64'(DNA_SIM_VALUE));
        chk("rd0_valid", 64'(bus.dna_valid), 64'd1);
        chk("rd0_busy_done", 64'(bus.busy), 64'd1);
        chk("rd0_read_cycles", 64'(rd_cnt - r0), 64'd2);
        chk("rd0_shift_cycles", 64'(sh_cnt - s0), 64'(2 * L));
        @(negedge clock);
        chk("rd0_idle_busy", 64'(bus.busy), 64'd0);
        chk("rd0_idle_valid", 64'(bus.dna_valid), 64'd1);

        // Both requesters after reset: index 0 first.
        do_reset();
        chk("rst2_valid", 64'(bus.dna_valid), 64'd0);
        bus.req = 2'b11;
        wait_ack("pair0", 2'b01, LAT);
        wait_ack("pair1", 2'b10, CACHE ? 2 : LAT + 1);

        // Repeat request: cached serve or fresh read.
        repeat (3) @(negedge clock);
        r0 = rd_cnt;
        bus.req = 2'b10;
        wait_ack("again", 2'b10, CACHE ? 1 : LAT);
        chk("again_reads", 64'(rd_cnt - r0), CACHE ? 64'd0 : 64'd2);
        chk("again_busy", 64'(bus.busy), CACHE ? 64'd0 : 64'd1);
        chk("again_dna", 64'(bus.dna), 64'(DNA_SIM_VALUE));

        // Reset during SHIFT cycle 40 aborts without ack; held req restarts the read.
        repeat (2) @(negedge clock);
        if (CACHE) do_reset();
        bus.req = 2'b01;
        k = 0;
        while (!dna_shift && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("abort_reach_shift", 64'(dna_shift), 64'd1);
        repeat (40) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_dna", 64'(bus.dna), 64'd0);
        chk("abort_valid", 64'(bus.dna_valid), 64'd0);
        chk("abort_ack", 64'(bus.ack), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_pins", 64'({dna_clk, dna_read, dna_shift}), 64'd0);
        reset = 1'b1;
        wait_ack("restart", 2'b01, LAT);
        chk("restart_dna", 64'(bus.dna), 64'(DNA_SIM_VALUE));

        // Requester 1 drops its req mid-read; the ack still arrives.
        do_reset();
        bus.req = 2'b10;
        repeat (20) @(negedge clock);
        bus.req = 2'b00;
        wait_ack("drop", 2'b10, LAT - 20);
        @(negedge clock);
        chk("drop_idle", 64'(bus.busy), 64'd0);
        chk("drop_ack_clear", 64'(bus.ack), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
